// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority vote,
// parity/framing/overrun reporting and a valid/ready output handshake.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_datain,
  output logic [DATA_BITS-1:0] o_dataout,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID       = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] LAST_DATA = DW'(DATA_BITS - 1);
  localparam logic          ODD       = (PARITY_MODE == 2);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [2:0]           r_hist;
  logic [CW-1:0]        r_bitCnt;
  logic [DW-1:0]        r_dataCnt;
  logic                 r_stopCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;

  logic w_voted;
  logic w_mid;
  logic w_fall;

  assign w_voted = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  assign w_mid   = (r_bitCnt == MID);
  assign w_fall  = r_hist[0] & ~r_sync2;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
    end else begin
      r_sync1 <= i_datain;
      r_sync2 <= r_sync1;
      r_hist  <= {r_hist[1:0], r_sync2};
    end
  end

  // A completed frame may be loaded in the same cycle the consumer takes the old
  // word; the completion assignment to o_valid overrides the handshake clear.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_bitCnt     <= '0;
      r_dataCnt    <= '0;
      r_stopCnt    <= 1'b0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      o_dataout    <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (r_state != IDLE) r_bitCnt <= (r_bitCnt == LAST_CLK) ? '0 : r_bitCnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state  <= START;
            r_bitCnt <= '0;
            o_busy   <= 1'b1;
          end
        end
        START: begin
          if (w_mid) begin
            if (w_voted) begin
              r_state <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              r_state   <= DATA;
              r_dataCnt <= '0;
              r_perr    <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_mid) begin
            r_shift <= {w_voted, r_shift[DATA_BITS-1:1]};
            if (r_dataCnt == LAST_DATA) begin
              r_dataCnt <= '0;
              r_stopCnt <= 1'b0;
              r_state   <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              r_dataCnt <= r_dataCnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_mid) begin
            r_perr  <= (^r_shift) ^ w_voted ^ ODD;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_mid) begin
            if (!w_voted) begin
              o_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end else if (r_stopCnt == LAST_STOP) begin
              r_state <= IDLE;
              o_busy  <= 1'b0;
              if (!o_valid || i_ready) begin
                o_dataout    <= r_shift;
                o_parity_err <= r_perr;
                o_valid      <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              r_stopCnt <= 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          if (w_voted) begin
            r_state <= IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames driven into four receiver
// configurations, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic clk;
  logic rst_n;
  logic [3:0] line;
  logic [3:0] ready;
  logic [3:0] valid, perr, ferr, ovr, busy;
  logic [7:0] doutA, doutB, doutC;
  logic [8:0] doutD;
  logic [8:0] dout [4];

  assign dout[0] = {1'b0, doutA};
  assign dout[1] = {1'b0, doutB};
  assign dout[2] = {1'b0, doutC};
  assign dout[3] = doutD;

  // Four configurations: 8N1, 8E1, 8O1 and 9N2, each on its own serial line.
  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) dutA (
    .i_clk(clk), .i_reset(rst_n), .i_datain(line[0]), .o_dataout(doutA), .o_valid(valid[0]),
    .i_ready(ready[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overrun(ovr[0]),
    .o_busy(busy[0]));
  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dutB (
    .i_clk(clk), .i_reset(rst_n), .i_datain(line[1]), .o_dataout(doutB), .o_valid(valid[1]),
    .i_ready(ready[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overrun(ovr[1]),
    .o_busy(busy[1]));
  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) dutC (
    .i_clk(clk), .i_reset(rst_n), .i_datain(line[2]), .o_dataout(doutC), .o_valid(valid[2]),
    .i_ready(ready[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_overrun(ovr[2]),
    .o_busy(busy[2]));
  uart_rx_param #(.DATA_BITS(9), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2)) dutD (
    .i_clk(clk), .i_reset(rst_n), .i_datain(line[3]), .o_dataout(doutD), .o_valid(valid[3]),
    .i_ready(ready[3]), .o_parity_err(perr[3]), .o_frame_err(ferr[3]), .o_overrun(ovr[3]),
    .o_busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame format of each configuration, used by both stimulus and model.
  function automatic int dbits(input int k);
    return (k == 3) ? 9 : 8;
  endfunction
  function automatic int pmode(input int k);
    return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
  endfunction
  function automatic int sbits(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  // Reference latency from the line falling edge to o_valid.
  function automatic int expLat(input int k);
    return 3 + CPB / 2 + (dbits(k) + ((pmode(k) != 0) ? 1 : 0) + sbits(k)) * CPB;
  endfunction

  // Reference parity error: count ones of data plus parity bit.
  function automatic logic expPerr(input int k, input logic [8:0] data, input logic parBit);
    int ones;
    ones = parBit ? 1 : 0;
    for (int i = 0; i < dbits(k); i++) ones += data[i] ? 1 : 0;
    case (pmode(k))
      1:       return (ones % 2) == 1;
      2:       return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Cycle counter and per-receiver observation of handshakes and pulses.
  int cyc = 0;
  int accCnt[4]   = '{0, 0, 0, 0};
  int feCnt[4]    = '{0, 0, 0, 0};
  int ovCnt[4]    = '{0, 0, 0, 0};
  int busyCnt[4]  = '{0, 0, 0, 0};
  int validCnt[4] = '{0, 0, 0, 0};
  int riseCyc[4]  = '{0, 0, 0, 0};
  int startCyc[4] = '{0, 0, 0, 0};
  logic [8:0] lastWord[4] = '{9'h0, 9'h0, 9'h0, 9'h0};
  logic [8:0] prevWord[4] = '{9'h0, 9'h0, 9'h0, 9'h0};
  logic [3:0] lastPerr  = 4'h0;
  logic [3:0] prevValid = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample outputs on the falling edge; ready is only changed just after a
  // rising edge, so valid & ready here is exactly the next handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (valid[k] && !prevValid[k]) riseCyc[k] = cyc;
      if (valid[k]) validCnt[k]++;
      if (valid[k] && ready[k]) begin
        accCnt[k]++;
        prevWord[k] = lastWord[k];
        lastWord[k] = dout[k];
        lastPerr[k] = perr[k];
      end
      if (ferr[k]) feCnt[k]++;
      if (ovr[k]) ovCnt[k]++;
      if (busy[k]) busyCnt[k]++;
      prevValid[k] = valid[k];
    end
  end

  int nChecks = 0;
  int nFails  = 0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on line k; bitsToDrive < 0 sends the whole frame and
  // returns the line to idle, otherwise the frame is cut short.
  task automatic applyStimulus(input int k, input logic [8:0] data, input logic parBit,
                               input logic stopVal, input int spikeBit, input int bitsToDrive);
    logic bits[$];
    int n;
    bits.push_back(1'b0);
    for (int i = 0; i < dbits(k); i++) bits.push_back(data[i]);
    if (pmode(k) != 0) bits.push_back(parBit);
    for (int i = 0; i < sbits(k); i++) bits.push_back(stopVal);
    n = (bitsToDrive < 0) ? bits.size() : bitsToDrive;
    @(negedge clk);
    startCyc[k] = cyc;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CPB; c++) begin
        line[k] = (i == spikeBit && c == CPB / 2) ? ~bits[i] : bits[i];
        @(negedge clk);
      end
    end
    if (bitsToDrive < 0) line[k] = 1'b1;
  endtask

  // Send a frame with ready held high and compare against the model.
  task automatic sendAndCheck(input int k, input logic [8:0] data, input logic parBit,
                              input logic stopVal, input int spikeBit, input string tag);
    int a0, f0, v0, lat, l;
    logic [8:0] w;
    a0 = accCnt[k];
    f0 = feCnt[k];
    v0 = validCnt[k];
    w  = data & 9'((1 << dbits(k)) - 1);
    applyStimulus(k, data, parBit, stopVal, spikeBit, -1);
    repeat (4) @(negedge clk);
    if (stopVal) begin
      l   = expLat(k);
      lat = riseCyc[k] - startCyc[k] - 1;
      checkOutput({tag, "_acc"}, accCnt[k] - a0, 1);
      checkOutput({tag, "_word"}, lastWord[k], w);
      checkOutput({tag, "_perr"}, lastPerr[k], expPerr(k, w, parBit));
      checkOutput({tag, "_vcyc"}, validCnt[k] - v0, 1);
      checkOutput({tag, "_lat"}, (lat >= l - 1 && lat <= l + 1) ? l : lat, l);
      checkOutput({tag, "_fe"}, feCnt[k] - f0, 0);
    end else begin
      checkOutput({tag, "_fe"}, feCnt[k] - f0, 1);
      checkOutput({tag, "_acc"}, accCnt[k] - a0, 0);
    end
  endtask

  int a0, b0, f0, o0;
  int k;
  logic [8:0] rData;
  logic rPar, rStop;

  initial begin
    line  = 4'hF;
    ready = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ferr", ferr, 0);
    checkOutput("rst_ovr", ovr, 0);
    checkOutput("rst_perr", perr, 0);
    checkOutput("rst_doutD", doutD, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic 8N1 frame with latency measurement.
    sendAndCheck(0, 9'h0A5, 1'b0, 1'b1, -1, "a5");

    // Short low glitch is a false start.
    b0 = busyCnt[0];
    a0 = accCnt[0];
    f0 = feCnt[0];
    @(negedge clk);
    line[0] = 1'b0;
    repeat (5) @(negedge clk);
    line[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checkOutput("glitch_busy_seen", busyCnt[0] > b0, 1);
    checkOutput("glitch_busy_idle", busy[0], 0);
    checkOutput("glitch_noval", accCnt[0] - a0, 0);
    checkOutput("glitch_nofe", feCnt[0] - f0, 0);

    // Single-cycle spikes mid data bit are voted out.
    sendAndCheck(0, 9'h000, 1'b0, 1'b1, 4, "spike00");
    sendAndCheck(0, 9'h0FF, 1'b0, 1'b1, 5, "spikeff");

    // Parity: 0x3C has an even number of ones.
    sendAndCheck(1, 9'h03C, 1'b1, 1'b1, -1, "even3c_p1");
    checkOutput("even3c_p1_flag", lastPerr[1], 1);
    sendAndCheck(1, 9'h03C, 1'b0, 1'b1, -1, "even3c_p0");
    checkOutput("even3c_p0_flag", lastPerr[1], 0);
    sendAndCheck(2, 9'h03C, 1'b1, 1'b1, -1, "odd3c_p1");
    checkOutput("odd3c_p1_flag", lastPerr[2], 0);
    sendAndCheck(2, 9'h03C, 1'b0, 1'b1, -1, "odd3c_p0");
    checkOutput("odd3c_p0_flag", lastPerr[2], 1);

    // Framing error, then a long break, then recovery.
    sendAndCheck(0, 9'h055, 1'b0, 1'b0, -1, "fe55");
    f0 = feCnt[0];
    a0 = accCnt[0];
    @(negedge clk);
    line[0] = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    line[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checkOutput("break_fe_once", feCnt[0] - f0, 1);
    checkOutput("break_noval", accCnt[0] - a0, 0);
    checkOutput("break_idle", busy[0], 0);
    sendAndCheck(0, 9'h081, 1'b0, 1'b1, -1, "after_break81");

    // Overrun: consumer stalled across two frames.
    @(posedge clk);
    #1 ready[0] = 1'b0;
    o0 = ovCnt[0];
    a0 = accCnt[0];
    applyStimulus(0, 9'h011, 1'b0, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    checkOutput("ovr_first_valid", valid[0], 1);
    applyStimulus(0, 9'h022, 1'b0, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    checkOutput("ovr_pulse", ovCnt[0] - o0, 1);
    checkOutput("ovr_hold_word", dout[0], 9'h011);
    checkOutput("ovr_hold_valid", valid[0], 1);
    checkOutput("ovr_no_acc", accCnt[0] - a0, 0);
    @(posedge clk);
    #1 ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ovr_drain_valid", valid[0], 0);
    checkOutput("ovr_drain_word", lastWord[0], 9'h011);
    checkOutput("ovr_drain_acc", accCnt[0] - a0, 1);

    // Frame completing in the cycle the consumer takes the previous word.
    @(posedge clk);
    #1 ready[0] = 1'b0;
    applyStimulus(0, 9'h044, 1'b0, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    checkOutput("same_old_valid", valid[0], 1);
    o0 = ovCnt[0];
    fork
      applyStimulus(0, 9'h033, 1'b0, 1'b1, -1, -1);
      begin
        @(negedge clk);
        #1;
        wait (cyc == startCyc[0] + expLat(0));
        #1 ready[0] = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    checkOutput("same_no_ovr", ovCnt[0] - o0, 0);
    checkOutput("same_old_taken", prevWord[0], 9'h044);
    checkOutput("same_new_word", lastWord[0], 9'h033);
    checkOutput("same_valid_clr", valid[0], 0);

    // 9-bit, two stop bits, then reset mid-frame.
    sendAndCheck(3, 9'h1A5, 1'b0, 1'b1, -1, "d9_1a5");
    a0 = accCnt[3];
    f0 = feCnt[3];
    o0 = ovCnt[3];
    applyStimulus(3, 9'h0AA, 1'b0, 1'b1, -1, 4);
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy[3], 0);
    checkOutput("mid_rst_valid", valid[3], 0);
    checkOutput("mid_rst_dout", doutD, 0);
    line[3] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checkOutput("post_rst_acc", accCnt[3] - a0, 0);
    checkOutput("post_rst_fe", feCnt[3] - f0, 0);
    checkOutput("post_rst_ovr", ovCnt[3] - o0, 0);
    sendAndCheck(3, 9'h00F, 1'b0, 1'b1, -1, "d9_0f");

    // Randomized frames across all configurations.
    for (int r = 0; r < 24; r++) begin
      k     = $urandom_range(0, 3);
      rData = 9'($urandom);
      rPar  = 1'($urandom);
      rStop = ($urandom_range(0, 5) != 0);
      sendAndCheck(k, rData, rPar, rStop, -1, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
